// File: rtl/fetch_bp.sv
// Instruction-fetch stage: drives instruction BRAM, picks next PC (jumps, BHT-predicted branches, redirects).
// Latency: one cycle from inst_addr to command; redirect target appears the following cycle, no bubble.
// Backpressure: enable=0 holds pc/valid and re-reads the current word; redirects and BHT training still apply.

package inst_set_pkg;
  localparam logic [5:0] INST_JALR = 6'h12;
  localparam logic [5:0] INST_J    = 6'h02;
  localparam logic [5:0] INST_JAL  = 6'h03;
  localparam logic [5:0] INST_BEQ  = 6'h04;
  localparam logic [5:0] INST_BNE  = 6'h05;
  localparam logic [5:0] INST_BLEZ = 6'h06;
  localparam logic [5:0] INST_BGTZ = 6'h07;

  function automatic logic is_branch_inst(input logic [5:0] op);
    return (op == INST_BEQ) || (op == INST_BNE) || (op == INST_BLEZ) || (op == INST_BGTZ);
  endfunction
endpackage

module fetch_bp
  import inst_set_pkg::*;
#(
  parameter int          ADDR_W    = 17,
  parameter int          BHT_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter bit          BP_ENABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              update_valid,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_data,
  output logic [4:0]        jr_reg,
  input  logic [31:0]       jr_data,
  output logic              valid,
  output logic [31:0]       pc,
  output logic [31:0]       command,
  output logic              pred_taken
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_next;
  logic [31:0] br_off;
  logic [5:0]  opcode;
  logic        is_br;
  logic        ctr_taken;
  logic        unused_low_bits;

  assign opcode     = inst_data[31:26];
  assign is_br      = is_branch_inst(opcode);
  assign pred_taken = is_br & valid_q & ctr_taken;
  assign command    = inst_data;
  assign jr_reg     = inst_data[20:16];
  assign valid      = valid_q;
  // Internally pc sits one word before RESET_PC until the first fetch lands.
  assign pc         = valid_q ? pc_q : RESET_PC;

  assign unused_low_bits = ^{redirect_pc[1:0], jr_data[1:0]};

  // Next-PC priority: redirect, post-reset warm-up, jumps, predicted branch, fall-through.
  always_comb begin
    br_off  = {{14{inst_data[15]}}, inst_data[15:0], 2'b00};
    pc_next = pc_q + 32'd4;
    if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (!valid_q) begin
      pc_next = pc_q + 32'd4;
    end else if ((opcode == INST_J) || (opcode == INST_JAL)) begin
      pc_next = {pc_q[31:28], inst_data[25:0], 2'b00};
    end else if (opcode == INST_JALR) begin
      pc_next = {jr_data[31:2], 2'b00};
    end else if (pred_taken) begin
      pc_next = pc_q + 32'd4 + br_off;
    end
  end

  // Memory address: next PC when advancing or redirecting, current PC while stalled.
  always_comb begin
    if (!rstn) begin
      inst_addr = RESET_PC[ADDR_W+1:2];
    end else if (enable || redirect_valid) begin
      inst_addr = pc_next[ADDR_W+1:2];
    end else begin
      inst_addr = pc_q[ADDR_W+1:2];
    end
  end

  // PC/valid update; a redirect is taken even during a stall.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (!rstn) begin
      pc_d    = RESET_PC - 32'd4;
      valid_d = 1'b0;
    end else if (enable || redirect_valid) begin
      pc_d    = pc_next;
      valid_d = 1'b1;
    end
  end

  // PC/valid state register.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    valid_q <= valid_d;
  end

  if (BP_ENABLE) begin : g_bht
    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_upd_bits;

    assign rd_idx          = pc_q[IDX_W+1:2];
    assign wr_idx          = update_pc[IDX_W+1:2];
    assign ctr_taken       = bht_q[rd_idx][1];
    assign unused_upd_bits = ^{update_pc[31:IDX_W+2], update_pc[1:0]};

    // Saturating 2-bit counter training; reads see the pre-update value this cycle.
    always_comb begin
      bht_d = bht_q;
      if (!rstn) begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
          bht_d[i] = 2'b01;
        end
      end else if (update_valid) begin
        if (update_taken) begin
          if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
        end else begin
          if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
        end
      end
    end

    // BHT state register.
    always_ff @(posedge clk) begin
      bht_q <= bht_d;
    end
  end else begin : g_static
    logic unused_upd;
    assign ctr_taken  = 1'b0;
    assign unused_upd = ^{update_valid, update_taken, update_pc};
  end

endmodule

// File: doc/fetch_bp.md
Name: fetch_bp

Overview:
- Parametrised instruction-fetch stage with dynamic branch prediction.
- Drives the synchronous instruction memory and computes the next PC. Unconditional jumps (J, JAL, JALR) are resolved in fetch.
- Conditional branches are predicted from a 2-bit-counter branch history table (BHT). The execute stage trains the BHT and corrects mispredictions through a redirect port.
- Sits between the instruction BRAM and decode. Uses opcode constants and is_branch_inst() from inst_set.sv.

Parameters:
- ADDR_W, 17, word-address width of the instruction memory.
- BHT_DEPTH, 256, number of BHT entries; power of two, minimum 2.
- RESET_PC, 32'h0, first fetched byte address after reset.
- BP_ENABLE, 1, 1 = BHT prediction; 0 = static not-taken (BHT not instantiated, pred_taken tied to 0).

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rstn, input, 1, reset; synchronous, active-low.
- enable, input, 1, 1 = advance; 0 = stall (pc, valid and BHT reads hold).
- redirect_valid, input, 1, single-cycle pulse from execute: restart fetch at redirect_pc.
- redirect_pc, input, 32, corrected byte address; bits [1:0] ignored.
- update_valid, input, 1, BHT training strobe from execute.
- update_pc, input, 32, byte PC of the resolved branch.
- update_taken, input, 1, actual branch outcome.
- inst_addr, output, ADDR_W, word address to instruction memory.
- inst_data, input, 32, memory data for the address sampled at the previous posedge.
- jr_reg, output, 5, command[20:16]; register-file read index for JALR.
- jr_data, input, 32, register-file value of jr_reg (combinational).
- valid, output, 1, command/pc hold a live instruction.
- pc, output, 32, byte address of command.
- command, output, 32, current instruction (= inst_data).
- pred_taken, output, 1, prediction applied to command (0 for non-branches).

Behaviour:
Reset
- Synchronous: on a posedge with rstn=0, pc <= RESET_PC, valid <= 0, all BHT counters <= 2'b01 (weakly not-taken).
- While rstn=0, inst_addr = RESET_PC[ADDR_W+1:2].
- Reset asserted mid-operation discards in-flight state and any same-cycle redirect or update.

Next-PC selection (combinational, priority high to low)
1. redirect_valid: redirect_pc & ~3.
2. valid=0: pc + 4 (first post-reset cycle only; see Valid).
3. opcode = INST_J or INST_JAL: {pc[31:28], command[25:0], 2'b00}.
4. opcode = INST_JALR: {jr_data[31:2], 2'b00}.
5. is_branch_inst(opcode) and pred_taken: pc + 4 + (sext(command[15:0]) << 2).
6. Otherwise: pc + 4.
- All arithmetic is 32-bit, wrapping modulo 2^32.

Memory address and stall
- inst_addr = (enable | redirect_valid) ? pc_next[ADDR_W+1:2] : pc[ADDR_W+1:2].
- While stalled the memory re-reads the current pc, so command stays stable.
- A redirect during a stall is accepted: pc <= redirect target even if enable=0.
- Redirect plus stall in the same cycle: pc <= target and valid <= 1. Decode must not consume while enable=0.

Valid
- Post-reset sequence: first active cycle shows valid=0 and the memory returns RESET_PC; next edge sets pc <= RESET_PC and valid <= 1.
- The block therefore holds pc at RESET_PC-4 internally for one cycle; pc observed with valid=1 starts at RESET_PC.
- No bubble on redirect: the instruction at the target appears one cycle after the redirect pulse, with valid=1.

Prediction and BHT
- Index = pc[log2(BHT_DEPTH)+1:2]; pred_taken = is_branch_inst(opcode) & valid & counter[1].
- Training: on update_valid, the entry at update_pc index saturates upward if update_taken (max 2'b11), otherwise downward (min 2'b00).
- Read and update to the same index in the same cycle: prediction uses the old value; the new value is visible next cycle.
- Training proceeds regardless of enable.
- Aliasing across entries is permitted (no tags).

Test Plan:
- Reset release with RESET_PC=0, memory holding NOPs -> cycle 1 valid=0; then pc=0,4,8,... with valid=1 each cycle; inst_addr leads pc by one word.
- J with command[25:0]=26'h40 at pc=0x10 -> next pc=0x100; no bubble.
- JALR at pc=0x20, jr_data=0x203 -> next pc=0x200; jr_reg equals command[20:16].
- Branch at pc=0x40, imm=-4, BHT reset state -> pred_taken=0, next pc 0x44. After two update_taken=1 pulses for pc 0x40 -> pred_taken=1, next pc 0x34. Three update_taken=0 pulses -> counter 00, not-taken.
- enable=0 for 3 cycles at pc=0x80 -> pc, command and inst_addr hold. redirect_valid with redirect_pc=0x1002 during the stall -> pc=0x1000 next cycle, valid=1.
- BP_ENABLE=0 with the same branch training -> pred_taken stays 0 and the fall-through path is always taken; rstn pulsed mid-stream -> pc returns to RESET_PC and valid drops for one cycle.
